// File: rtl/tdpram_pkg.sv
// -----------------------------------------------------------------------------
// tdpram_pkg
// Shared types and elaboration helpers for the single-clock true dual-port RAM.
//   state_t          : controller state (INIT = clear sweep, RUN = normal)
//   depth_of()       : number of words for a given address width
//   read_latency_ok(): legal READ_LATENCY values (1 or 2)
// -----------------------------------------------------------------------------
package tdpram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/tdpram_rd_pipe.sv
// -----------------------------------------------------------------------------
// tdpram_rd_pipe
// Per-port read pipeline: turns an accepted read (rd_en + the addressed word)
// into rvalid/dout exactly READ_LATENCY cycles later. dout only loads when the
// final stage is valid, so it holds between reads. Asynchronous reset clears
// every stage, dropping any in-flight read.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   rd_en, rd_data       : accepted read strobe and the word read from memory
//   rvalid, dout         : read-valid pulse and held read data
// -----------------------------------------------------------------------------
module tdpram_rd_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_vld_q, s1_vld_d;
      logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

      always_comb begin
        s1_vld_d  = rd_en;
        s1_data_d = rd_en ? rd_data : s1_data_q;
        vld_d     = s1_vld_q;
        dout_d    = s1_vld_q ? s1_data_q : dout_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_vld_q  <= 1'b0;
          s1_data_q <= '0;
        end else begin
          s1_vld_q  <= s1_vld_d;
          s1_data_q <= s1_data_d;
        end
      end
    end else begin : g_lat1
      always_comb begin
        vld_d  = rd_en;
        dout_d = rd_en ? rd_data : dout_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

  assign rvalid = vld_q;
  assign dout   = dout_q;

endmodule

// File: rtl/tdpram_sync.sv
// -----------------------------------------------------------------------------
// tdpram_sync
// Single-clock true dual-port RAM. Two symmetric read/write ports, read-first
// across ports, port A wins a same-address write/write collision.
// Optional feature macro: TDPRAM_INIT_CLEAR_EN -- after reset, sweep zeros
// into every address (one per cycle) before accepting requests.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   we_x, re_x, addr_x, din_x (x=a,b) : write/read enables, address, write data
//   dout_x, rvalid_x                  : held read data, one-cycle read-valid
//   collision                         : pulse after both ports wrote one address
//   init_done                         : requests are accepted while high
// -----------------------------------------------------------------------------
module tdpram_sync
  import tdpram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  rvalid_a,
  input  logic                  we_b,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  rvalid_b,
  output logic                  collision,
  output logic                  init_done
);

  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

  generate
    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("tdpram_sync: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic            collision_q, collision_d;
  logic            run, wr_a, wr_b_req, wr_b, rd_a, rd_b;
  logic            sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef TDPRAM_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  // Extra MSB marks "every address written"; RUN is entered one cycle later.
  logic [ADDR_WIDTH:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    sweep_we   = 1'b0;
    sweep_addr = clr_cnt_q[ADDR_WIDTH-1:0];
    if (state_q == INIT) begin
      if (clr_cnt_q[ADDR_WIDTH]) begin
        state_d = RUN;
      end else begin
        sweep_we  = 1'b1;
        clr_cnt_d = clr_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clr_cnt_q <= '0;
    else          clr_cnt_q <= clr_cnt_d;
  end
`else
  localparam state_t RESET_STATE = RUN;

  always_comb begin
    state_d    = state_q;
    sweep_we   = 1'b0;
    sweep_addr = '0;
  end
`endif

  // Request qualification and write arbitration.
  always_comb begin
    run         = (state_q == RUN);
    wr_a        = run & we_a;
    wr_b_req    = run & we_b;
    wr_b        = wr_b_req & ~(wr_a & (addr_a == addr_b));
    rd_a        = run & re_a & ~we_a;   // same-port write drops the read
    rd_b        = run & re_b & ~we_b;
    collision_d = wr_a & wr_b_req & (addr_a == addr_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      collision_q <= collision_d;
    end
  end

  // Storage: no reset; cleared only by the sweep.
  always_ff @(posedge clk) begin
    if (sweep_we) mem[sweep_addr] <= '0;
    if (wr_a)     mem[addr_a]     <= din_a;
    if (wr_b)     mem[addr_b]     <= din_b;
  end

  // The read pipes capture the pre-write word at the clock edge: read-first.
  tdpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_a (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_a), .rd_data(mem[addr_a]),
    .rvalid(rvalid_a), .dout(dout_a)
  );

  tdpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_b (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_b), .rd_data(mem[addr_b]),
    .rvalid(rvalid_b), .dout(dout_b)
  );

  assign collision = collision_q;
  assign init_done = run;

endmodule

// File: tb/tb_tdpram_sync.sv
// -----------------------------------------------------------------------------
// tb_tdpram_sync
// Two instances: dut0 with READ_LATENCY=1, dut1 with READ_LATENCY=2.
// Stimulus pushes expected {stream id, data, cycle} entries into a scoreboard;
// a negedge monitor pops an entry whenever rvalid or collision is seen.
// Stream ids: 0=dut0.A 1=dut0.B 2=dut1.A 3=dut1.B 4=dut0.coll 5=dut1.coll
// -----------------------------------------------------------------------------
module tb_tdpram_sync;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

`ifdef TDPRAM_INIT_CLEAR_EN
  localparam bit RST_INIT_DONE = 1'b0;
  localparam bit SWEEP         = 1'b1;
`else
  localparam bit RST_INIT_DONE = 1'b1;
  localparam bit SWEEP         = 1'b0;
`endif

  logic       clk;
  logic       rst_n     [2];
  logic       we_a      [2];
  logic       re_a      [2];
  logic [3:0] addr_a    [2];
  logic [7:0] din_a     [2];
  logic [7:0] dout_a    [2];
  logic       rvalid_a  [2];
  logic       we_b      [2];
  logic       re_b      [2];
  logic [3:0] addr_b    [2];
  logic [7:0] din_b     [2];
  logic [7:0] dout_b    [2];
  logic       rvalid_b  [2];
  logic       collision [2];
  logic       init_done [2];

  // {i, ~i} for i = 0..15
  logic [7:0] pat [16] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
                           8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  tdpram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1)) dut0 (
    .clk(clk), .reset_n(rst_n[0]),
    .we_a(we_a[0]), .re_a(re_a[0]), .addr_a(addr_a[0]), .din_a(din_a[0]),
    .dout_a(dout_a[0]), .rvalid_a(rvalid_a[0]),
    .we_b(we_b[0]), .re_b(re_b[0]), .addr_b(addr_b[0]), .din_b(din_b[0]),
    .dout_b(dout_b[0]), .rvalid_b(rvalid_b[0]),
    .collision(collision[0]), .init_done(init_done[0])
  );

  tdpram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut1 (
    .clk(clk), .reset_n(rst_n[1]),
    .we_a(we_a[1]), .re_a(re_a[1]), .addr_a(addr_a[1]), .din_a(din_a[1]),
    .dout_a(dout_a[1]), .rvalid_a(rvalid_a[1]),
    .we_b(we_b[1]), .re_b(re_b[1]), .addr_b(addr_b[1]), .din_b(din_b[1]),
    .dout_b(dout_b[1]), .rvalid_b(rvalid_b[1]),
    .collision(collision[1]), .init_done(init_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("check %s act=%0h exp=%0h ok", name, act, exp);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor side: pop the oldest entry of this stream and compare data and cycle.
  task automatic mon(input int id, input logic [7:0] d);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].id == id) idx = i;
    total++;
    if (idx < 0) begin
      $display("FAIL unexpected_output stream=%0d data=%h cyc=%0d exp=none", id, d, cyc);
    end else begin
      e = sb[idx];
      sb.delete(idx);
      if (e.data === d && e.cyc == cyc) begin
        passed++;
        $display("mon stream=%0d data=%h cyc=%0d ok", id, d, cyc);
      end else begin
        $display("FAIL stream%0d_out act=%h@%0d exp=%h@%0d", id, d, cyc, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rvalid_a[d] === 1'b1)  mon(2 * d, dout_a[d]);
      if (rvalid_b[d] === 1'b1)  mon(2 * d + 1, dout_b[d]);
      if (collision[d] === 1'b1) mon(4 + d, 8'h00);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    we_a[d] = 1'b0; re_a[d] = 1'b0; addr_a[d] = '0; din_a[d] = '0;
    we_b[d] = 1'b0; re_b[d] = 1'b0; addr_b[d] = '0; din_b[d] = '0;
  endtask

  task automatic push(input int id, input logic [7:0] data, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // One request cycle on dut d; xa/xb < 0 means no read response expected.
  task automatic op(input int d,
                    input bit wa, input bit ra, input logic [3:0] aa, input logic [7:0] da, input int xa,
                    input bit wb, input bit rb, input logic [3:0] ab, input logic [7:0] db, input int xb,
                    input bit coll);
    int lat;
    lat = (d == 0) ? 1 : 2;
    we_a[d] = wa; re_a[d] = ra; addr_a[d] = aa; din_a[d] = da;
    we_b[d] = wb; re_b[d] = rb; addr_b[d] = ab; din_b[d] = db;
    if (xa >= 0) push(2 * d, xa[7:0], lat);
    if (xb >= 0) push(2 * d + 1, xb[7:0], lat);
    if (coll)    push(4 + d, 8'h00, 1);
    $display("op dut%0d cyc=%0d A:we=%0b re=%0b a=%h d=%h B:we=%0b re=%0b a=%h d=%h",
             d, cyc, wa, ra, aa, da, wb, rb, ab, db);
    step();
    idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      idle(d);
    end
    repeat (3) step();

    // Reset values
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_dout_a%0d", d),    64'(dout_a[d]),    64'h0);
      check($sformatf("rst_dout_b%0d", d),    64'(dout_b[d]),    64'h0);
      check($sformatf("rst_rvalid_a%0d", d),  64'(rvalid_a[d]),  64'h0);
      check($sformatf("rst_rvalid_b%0d", d),  64'(rvalid_b[d]),  64'h0);
      check($sformatf("rst_collision%0d", d), 64'(collision[d]), 64'h0);
      check($sformatf("rst_init_done%0d", d), 64'(init_done[d]), 64'(RST_INIT_DONE));
    end

    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    if (SWEEP) begin
      // Reads issued during the sweep must be ignored; init_done rises 17 edges in.
      for (int n = 1; n <= 17; n++) begin
        for (int d = 0; d < 2; d++) begin
          re_a[d] = 1'b1; addr_a[d] = n[3:0];
          re_b[d] = 1'b1; addr_b[d] = 4'(16 - n);
        end
        step();
        if (n >= 16) check($sformatf("sweep_init_done_n%0d", n), 64'(init_done[0]), 64'(n == 17));
      end
      idle(0);
      idle(1);
      for (int a = 0; a < 16; a++)
        op(0, 1'b0, 1'b1, 4'(a), 8'h00, 0, 1'b0, 1'b1, 4'(15 - a), 8'h00, 0, 1'b0);
      for (int a = 0; a < 16; a++)
        op(1, 1'b0, 1'b1, 4'(a), 8'h00, 0, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    end else begin
      step();
      check("run_init_done", 64'(init_done[0]), 64'h1);
    end

    // Write then cross-port read
    op(0, 1'b1, 1'b0, 4'h3, 8'hA5, -1, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    op(0, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0, 1'b1, 4'h3, 8'h00, 8'hA5, 1'b0);
    // Write/write collision at address 7: A wins; then same-address dual read
    op(0, 1'b1, 1'b0, 4'h7, 8'h11, -1, 1'b1, 1'b0, 4'h7, 8'h22, -1, 1'b1);
    op(0, 1'b0, 1'b1, 4'h7, 8'h00, 8'h11, 1'b0, 1'b1, 4'h7, 8'h00, 8'h11, 1'b0);
    // Read-first across ports
    op(0, 1'b1, 1'b0, 4'h5, 8'h3C, -1, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    op(0, 1'b1, 1'b0, 4'h5, 8'h77, -1, 1'b0, 1'b1, 4'h5, 8'h00, 8'h3C, 1'b0);
    op(0, 1'b0, 1'b1, 4'h5, 8'h00, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    // Same-port write+read: write lands, read dropped
    op(0, 1'b1, 1'b1, 4'h9, 8'h5A, -1, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    op(0, 1'b0, 1'b1, 4'h9, 8'h00, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0);
    // Parallel writes to different addresses, no collision
    op(0, 1'b1, 1'b0, 4'h1, 8'h01, -1, 1'b1, 1'b0, 4'h2, 8'h02, -1, 1'b0);
    op(0, 1'b0, 1'b1, 4'h1, 8'h00, 8'h01, 1'b0, 1'b1, 4'h2, 8'h00, 8'h02, 1'b0);
    // dout holds between reads
    repeat (3) step();
    check("hold_dout_b0", 64'(dout_b[0]), 64'h02);
    check("hold_rvalid_b0", 64'(rvalid_b[0]), 64'h0);

    // dut1 (latency 2): fill, then stream port B 0..15 with port A in reverse
    for (int i = 0; i < 8; i++)
      op(1, 1'b1, 1'b0, 4'(i), pat[i], -1, 1'b1, 1'b0, 4'(i + 8), pat[i + 8], -1, 1'b0);
    for (int i = 0; i < 16; i++)
      op(1, 1'b0, 1'b1, 4'(15 - i), 8'h00, int'(pat[15 - i]), 1'b0, 1'b1, 4'(i), 8'h00, int'(pat[i]), 1'b0);
    repeat (4) step();

    // Reset mid-stream on dut1
    for (int i = 0; i < 6; i++)
      op(1, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0, 1'b1, 4'(i), 8'h00, int'(pat[i]), 1'b0);
    check("pre_rst_rvalid_b1", 64'(rvalid_b[1]), 64'h1);
    rst_n[1] = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].id == 2 || sb[i].id == 3 || sb[i].id == 5) sb.delete(i);
    #2;
    check("async_rst_rvalid_b1", 64'(rvalid_b[1]), 64'h0);
    check("async_rst_dout_b1",   64'(dout_b[1]),   64'h0);
    repeat (3) step();
    rst_n[1] = 1'b1;
    repeat (20) step();
    op(1, 1'b0, 1'b0, 4'h0, 8'h00, -1, 1'b0, 1'b1, 4'h4, 8'h00, (SWEEP ? 0 : int'(pat[4])), 1'b0);
    repeat (4) step();

    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
